// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared encodings and defaults for the CIM macro controller
package cim_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] OP_WR    = 2'b00;
  localparam logic [1:0] OP_WRBUF = 2'b01;
  localparam logic [1:0] OP_COMP  = 2'b10;
  localparam logic [1:0] OP_RD    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_SET,
    S_SHIFT,
    S_WAIT,
    S_READ,
    S_CAPT,
    S_RESP
  } cim_state_e;

endpackage

// File: rtl/cim_bit_serializer.sv
// rtl/cim_bit_serializer.sv - LSB-first bit serializer for the compute input vector
module cim_bit_serializer #(
  parameter int IN_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [IN_BITS-1:0] vec,
  output logic               sbit,
  output logic               done
);

  localparam int CNT_W = $clog2(IN_BITS + 1);

  logic [IN_BITS-1:0] sreg;
  logic [CNT_W-1:0]   cnt;

  // Load puts bit 0 on the output at once; each shift presents the next bit,
  // and the shift that consumes the last bit (done high) returns the output to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
      sbit <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      sbit <= vec[0];
      sreg <= vec >> 1;
      cnt  <= CNT_W'(IN_BITS - 1);
      done <= (IN_BITS == 1);
    end else if (shift) begin
      if (done) begin
        sbit <= 1'b0;
        done <= 1'b0;
      end else begin
        sbit <= sreg[0];
        sreg <= sreg >> 1;
        cnt  <= cnt - 1'b1;
        done <= (cnt == CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/cim_macro_ctrl.sv
// rtl/cim_macro_ctrl.sv - command sequencer driving the SRAM compute-in-memory macro pins
module cim_macro_ctrl
  import cim_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IN_BITS  = 8,
  parameter int WAIT_CYC = 2,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_model,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] cim_a,
  output logic [DATA_W-1:0] cim_d,
  output logic              cim_wrt,
  output logic              cim_wrtbuf,
  output logic              cim_comp,
  output logic              cim_model,
  output logic              cim_wait,
  output logic              cim_inbit,
  output logic              cim_set,
  output logic              cim_read,
  input  logic [DATA_W-1:0] cim_q
);

  localparam int WAIT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam int LAT_W  = $clog2(READ_LAT + 1);

  cim_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0] a_d;
  logic [DATA_W-1:0] d_d, rsp_data_d;
  logic              model_d, wrt_d, wrtbuf_d, set_d, comp_d, wait_d, read_d, rsp_valid_d;
  logic              ser_load, ser_done;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

  cim_bit_serializer #(.IN_BITS(IN_BITS)) u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .shift (state_q == S_SHIFT),
    .vec   (cim_d[IN_BITS-1:0]),
    .sbit  (cim_inbit),
    .done  (ser_done)
  );

  // Next state plus next value of every registered pin; strobes default low so
  // each state raises exactly the strobe of the state it is about to enter.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    a_d         = cim_a;
    d_d         = cim_d;
    model_d     = cim_model;
    rsp_data_d  = rsp_data;
    wrt_d       = 1'b0;
    wrtbuf_d    = 1'b0;
    set_d       = 1'b0;
    comp_d      = 1'b0;
    wait_d      = 1'b0;
    read_d      = 1'b0;
    rsp_valid_d = 1'b0;
    ser_load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d = cmd_addr;
          case (cmd_op)
            OP_WR, OP_WRBUF: begin
              state_d  = S_WRITE;
              d_d      = cmd_data;
              wrt_d    = (cmd_op == OP_WR);
              wrtbuf_d = (cmd_op == OP_WRBUF);
            end
            OP_COMP: begin
              state_d = S_SET;
              d_d     = cmd_data;
              model_d = cmd_model;
              set_d   = 1'b1;
            end
            default: begin
              state_d = S_READ;
              read_d  = 1'b1;
            end
          endcase
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_SET: begin
        state_d  = S_SHIFT;
        comp_d   = 1'b1;
        ser_load = 1'b1;
      end
      S_SHIFT: begin
        if (!ser_done) begin
          comp_d = 1'b1;
        end else if (WAIT_CYC == 0) begin
          state_d = S_READ;
          read_d  = 1'b1;
        end else begin
          state_d    = S_WAIT;
          wait_d     = 1'b1;
          wait_cnt_d = WAIT_W'(WAIT_CYC - 1);
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = S_READ;
          read_d  = 1'b1;
        end else begin
          wait_d     = 1'b1;
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_READ: begin
        state_d   = S_CAPT;
        lat_cnt_d = LAT_W'(READ_LAT - 1);
      end
      S_CAPT: begin
        if (lat_cnt_q == '0) begin
          state_d     = S_RESP;
          rsp_data_d  = cim_q;
          rsp_valid_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
        else           rsp_valid_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and all macro/response pins are flops; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      lat_cnt_q  <= '0;
      cim_a      <= '0;
      cim_d      <= '0;
      cim_model  <= 1'b0;
      cim_wrt    <= 1'b0;
      cim_wrtbuf <= 1'b0;
      cim_set    <= 1'b0;
      cim_comp   <= 1'b0;
      cim_wait   <= 1'b0;
      cim_read   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      cim_a      <= a_d;
      cim_d      <= d_d;
      cim_model  <= model_d;
      cim_wrt    <= wrt_d;
      cim_wrtbuf <= wrtbuf_d;
      cim_set    <= set_d;
      cim_comp   <= comp_d;
      cim_wait   <= wait_d;
      cim_read   <= read_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_cim_macro_ctrl.sv
// tb/tb_cim_macro_ctrl.sv - self-checking bench for cim_macro_ctrl with macro and scoreboard models
module tb_cim_macro_ctrl;
  import cim_pkg::*;

  localparam int IN_BITS  = 8;
  localparam int WAIT_CYC = 2;
  localparam int READ_LAT = 1;
  localparam int LAT2     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_model, rsp_valid, rsp_ready, busy;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_addr, cim_a;
  logic [15:0] cmd_data, rsp_data, cim_d, cim_q;
  logic        cim_wrt, cim_wrtbuf, cim_comp, cim_model, cim_wait, cim_inbit, cim_set, cim_read;

  logic        b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_busy;
  logic [8:0]  b_cim_a;
  logic [15:0] b_rsp_data, b_cim_d, b_cim_q;
  logic        b_wrt, b_wrtbuf, b_comp, b_model, b_wait, b_inbit, b_set, b_read;

  logic [5:0] stb, b_stb;
  assign stb   = {cim_wrt, cim_wrtbuf, cim_set, cim_comp, cim_wait, cim_read};
  assign b_stb = {b_wrt, b_wrtbuf, b_set, b_comp, b_wait, b_read};

  cim_macro_ctrl #(.ADDR_W(9), .DATA_W(16), .IN_BITS(IN_BITS), .WAIT_CYC(WAIT_CYC), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_model(cmd_model), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy), .cim_a(cim_a), .cim_d(cim_d),
    .cim_wrt(cim_wrt), .cim_wrtbuf(cim_wrtbuf), .cim_comp(cim_comp), .cim_model(cim_model),
    .cim_wait(cim_wait), .cim_inbit(cim_inbit), .cim_set(cim_set), .cim_read(cim_read), .cim_q(cim_q)
  );

  cim_macro_ctrl #(.ADDR_W(9), .DATA_W(16), .IN_BITS(IN_BITS), .WAIT_CYC(0), .READ_LAT(LAT2)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(OP_COMP),
    .cmd_addr(9'h000), .cmd_data(16'h0001), .cmd_model(1'b0), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .busy(b_busy), .cim_a(b_cim_a), .cim_d(b_cim_d),
    .cim_wrt(b_wrt), .cim_wrtbuf(b_wrtbuf), .cim_comp(b_comp), .cim_model(b_model),
    .cim_wait(b_wait), .cim_inbit(b_inbit), .cim_set(b_set), .cim_read(b_read), .cim_q(b_cim_q)
  );

  // Macro model: weight array, collects serial input bits, q valid READ_LAT cycles after read.
  logic [15:0] mm_mem [0:511];
  logic        mm_comp, rd_v;
  logic [7:0]  mm_vec;
  int          mm_idx;
  logic [15:0] mm_rdval;
  logic [2:0]  b_pipe;

  always @(posedge clk) begin
    if (rst) begin
      mm_comp <= 1'b0;
      mm_idx  <= 0;
      rd_v    <= 1'b0;
      b_pipe  <= '0;
    end else begin
      if (cim_wrt) mm_mem[cim_a] <= cim_d;
      if (cim_set) begin
        mm_comp <= 1'b1;
        mm_vec  <= '0;
        mm_idx  <= 0;
      end
      if (cim_comp && mm_idx < IN_BITS) begin
        mm_vec[mm_idx] <= cim_inbit;
        mm_idx         <= mm_idx + 1;
      end
      if (cim_read) begin
        mm_rdval <= mm_comp ? (mm_mem[cim_a] ^ {8'h00, mm_vec}) + {15'd0, cim_model} : mm_mem[cim_a];
        mm_comp  <= 1'b0;
      end
      rd_v   <= cim_read;
      b_pipe <= {b_pipe[1:0], b_read};
    end
  end
  assign cim_q   = rd_v ? mm_rdval : 16'hDEAD;
  assign b_cim_q = b_pipe[2] ? 16'h5A5A : 16'hDEAD;

  // Scoreboard state
  logic [15:0] ref_mem [0:511];
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] comp_ref(input logic [15:0] w, input logic [15:0] d, input logic m);
    logic [15:0] mask = 16'((1 << IN_BITS) - 1);
    return (w ^ (d & mask)) + {15'd0, m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [8:0] a, input logic [15:0] d, input logic m);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("issue_timeout", 0, 1);
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_model = m; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    case (op)
      OP_WR:   ref_mem[a] = d;
      OP_COMP: exp_q.push_back(comp_ref(ref_mem[a], d, m));
      OP_RD:   exp_q.push_back(ref_mem[a]);
      default: ;
    endcase
  endtask

  task automatic drain(input bit rnd);
    logic [15:0] e;
    bit got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid && rsp_ready) begin
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e);
        got = 1'b1;
      end
      tick();
    end
    rsp_ready = 1'b0;
    if (!got) check("rsp_timeout", 0, 1);
  endtask

  // Strobe exclusivity on both instances every cycle
  always @(negedge clk) begin
    if (!rst) begin
      check("onehot", $countones(stb) <= 1, 1);
      check("onehot2", $countones(b_stb) <= 1, 1);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] dummy;
    logic [1:0]  op;
    logic [8:0]  a;
    logic [15:0] d;
    bit          seen;
    int          rd_at, rv_at;

    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_model = 0; rsp_ready = 0;
    b_cmd_valid = 0; b_rsp_ready = 0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_strobes", stb, 0);
    check("rst_cim_a", cim_a, 0);
    check("rst_cim_d", cim_d, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_ready2", b_cmd_ready, 1);

    for (int i = 0; i < 16; i++) issue(OP_WR, 9'(i), 16'($urandom), 1'b0);

    // Write weight timing
    issue(OP_WR, 9'h1A5, 16'hBEEF, 1'b0);
    check("wr_strobes", stb, 6'b100000);
    check("wr_addr", cim_a, 9'h1A5);
    check("wr_data", cim_d, 16'hBEEF);
    check("wr_busy_ready", cmd_ready, 0);
    tick();
    check("wr_end_strobes", stb, 0);
    check("wr_end_ready", cmd_ready, 1);
    check("wr_no_rsp", rsp_valid, 0);
    issue(OP_WRBUF, 9'h010, 16'h7777, 1'b0);
    check("wrbuf_strobes", stb, 6'b010000);

    // Compute timing: weight chosen so the macro returns 0x1234
    issue(OP_WR, 9'h003, 16'h1286, 1'b0);
    issue(OP_COMP, 9'h003, 16'hA5B5, 1'b1);
    rd_at = 2 + IN_BITS + WAIT_CYC;
    rv_at = rd_at + READ_LAT + 1;
    for (int k = 1; k <= rv_at; k++) begin
      check($sformatf("comp_stb_k%0d", k), stb,
            {2'b00, k == 1, k >= 2 && k <= 1 + IN_BITS, k >= 2 + IN_BITS && k < rd_at, k == rd_at});
      if (k == 1) begin
        check("comp_addr", cim_a, 9'h003);
        check("comp_model", cim_model, 1);
      end
      if (k >= 2 && k <= 1 + IN_BITS) check($sformatf("comp_inbit_k%0d", k), cim_inbit, (16'h00B5 >> (k - 2)) & 1);
      check($sformatf("comp_rv_k%0d", k), rsp_valid, k == rv_at);
      if (k == rv_at) begin
        check("comp_q", rsp_data, 16'h1234);
        rsp_ready = 1'b1;
      end
      tick();
    end
    rsp_ready = 1'b0;
    dummy = exp_q.pop_front();
    check("comp_done_ready", cmd_ready, 1);
    check("comp_done_rv", rsp_valid, 0);

    // Read with stalled response; commands offered meanwhile must be ignored
    issue(OP_WR, 9'h0FF, 16'hA5A5, 1'b0);
    issue(OP_RD, 9'h0FF, 16'h0000, 1'b0);
    check("rd_strobe", stb, 6'b000001);
    check("rd_addr", cim_a, 9'h0FF);
    tick();
    tick();
    cmd_valid = 1'b1; cmd_op = OP_WR; cmd_addr = 9'h0FF; cmd_data = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, 16'hA5A5);
      check("stall_ready", cmd_ready, 0);
      check("stall_nowrt", stb, 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check("stall_release", rsp_valid, 1);
    tick();
    rsp_ready = 1'b0;
    dummy = exp_q.pop_front();
    check("stall_done_ready", cmd_ready, 1);
    check("stall_done_rv", rsp_valid, 0);
    issue(OP_RD, 9'h0FF, 16'h0000, 1'b0);
    drain(1'b0);

    // No-wait, 3-cycle latency instance
    check("b_idle", b_cmd_ready, 1);
    b_cmd_valid = 1'b1;
    tick();
    b_cmd_valid = 1'b0;
    rd_at = 2 + IN_BITS;
    rv_at = rd_at + LAT2 + 1;
    for (int k = 1; k <= rv_at; k++) begin
      check($sformatf("b_stb_k%0d", k), b_stb,
            {2'b00, k == 1, k >= 2 && k <= 1 + IN_BITS, 1'b0, k == rd_at});
      if (k >= 2 && k <= 1 + IN_BITS) check($sformatf("b_inbit_k%0d", k), b_inbit, k == 2);
      check($sformatf("b_rv_k%0d", k), b_rsp_valid, k == rv_at);
      if (k == rv_at) begin
        check("b_q", b_rsp_data, 16'h5A5A);
        b_rsp_ready = 1'b1;
      end
      tick();
    end
    b_rsp_ready = 1'b0;
    check("b_done_ready", b_cmd_ready, 1);

    // Reset during the 4th SHIFT cycle
    issue(OP_COMP, 9'h005, 16'h00FF, 1'b0);
    repeat (4) tick();
    check("rst_pre_comp", cim_comp, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_strobes", stb, 0);
    check("mid_rst_inbit", cim_inbit, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_rv", rsp_valid, 0);
    seen = 1'b0;
    repeat (20) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    check("mid_rst_no_rsp", seen, 0);
    exp_q.delete();
    issue(OP_WR, 9'h006, 16'h1357, 1'b0);
    check("post_rst_wrt", stb, 6'b100000);
    check("post_rst_addr", cim_a, 9'h006);
    check("post_rst_data", cim_d, 16'h1357);

    // Random command stream with random response back-pressure
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      op = 2'($urandom_range(0, 3));
      a  = 9'($urandom_range(0, 15));
      d  = 16'($urandom);
      issue(op, a, d, 1'($urandom_range(0, 1)));
      if (op == OP_COMP || op == OP_RD) drain(1'b1);
    end
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cim_macro_ctrl.md
Name: cim_macro_ctrl

Overview:
Host-side sequencer that drives the SRAM compute-in-memory macro's pin interface (address, data, write strobes, compute/set/wait/read controls, bit-serial input) and collects its 16-bit result bus.
- Accepts word-level commands from the system over a valid/ready port and expands each into the cycle-accurate pin sequence the macro needs.
- Returns compute and read results over a valid/ready response port.
- Sits between the system controller and the macro instance.

Parameters:
ADDR_W, 9, macro address width
DATA_W, 16, macro data / result width
IN_BITS, 8, bit-serial input precision (bits shifted per compute, 1..DATA_W)
WAIT_CYC, 2, settle cycles between last input bit and read (0 allowed)
READ_LAT, 1, cycles from read strobe to valid macro q (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 write weight, 01 write buffer, 10 compute, 11 read
cmd_addr  in  ADDR_W  target row/address
cmd_data  in  DATA_W  write data; for compute, input vector in [IN_BITS-1:0]
cmd_model  in  1  compute mode select
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumed when valid&ready
rsp_data  out  DATA_W  captured macro q
busy  out  1  high whenever state != IDLE
cim_a  out  ADDR_W  to macro a
cim_d  out  DATA_W  to macro d
cim_wrt, cim_wrtbuf, cim_comp, cim_model, cim_wait, cim_inbit, cim_set, cim_read  out  1 each  to macro pins of same role
cim_q  in  DATA_W  from macro q

Behaviour:
- Pin timing: all macro pins are driven from flops. A stated cycle means the pin is high during that cycle.
- Reset values: all outputs 0, except cmd_ready = 1 (IDLE). rst mid-operation: next cycle IDLE, all strobes 0, pending response dropped, rsp_valid 0.
- States: IDLE, WRITE, SET, SHIFT, WAIT, READ, CAPT, RESP.
- cmd_ready = 1 only in IDLE. Command fields are latched at the handshake (cycle T).
- Write weight (00): WRITE at T+1.
  - cim_wrt=1, cim_a=addr, cim_d=data.
  - IDLE at T+2. No response.
- Write buffer (01): as write weight, but cim_wrtbuf=1 instead of cim_wrt.
- Compute (10):
  - SET at T+1: cim_set=1, cim_a=addr, cim_model=cmd_model.
  - SHIFT T+2..T+1+IN_BITS: cim_comp=1, cim_inbit = data bit i, LSB first.
  - WAIT for WAIT_CYC cycles: cim_wait=1 (skipped if WAIT_CYC=0).
  - READ one cycle: cim_read=1.
  - CAPT for READ_LAT cycles; rsp_data <= cim_q in the last CAPT cycle.
  - RESP: rsp_valid=1.
- Read (11): READ at T+1, CAPT for READ_LAT cycles, then RESP. cim_model unchanged.
- RESP: hold rsp_valid and rsp_data stable until rsp_ready. Leave for IDLE on the handshake cycle (the cycle rsp_ready is high). A stalled response blocks new commands.
- Hold rules:
  - cim_a, cim_d, cim_model hold their last driven value between commands.
  - cim_d carries the latched cmd_data during compute.
- Strobe exclusivity: at most one of wrt/wrtbuf/set/comp/wait/read is high in any cycle. Any violation is a bug.
- Counters: bit counter of clog2(IN_BITS+1) bits; wait/latency counters of matching widths. No wrap-around; counters reload on entry to their state.
- cmd_valid in a non-IDLE state is ignored (not accepted, no side effects).
- Unused cmd_data bits above IN_BITS-1 are ignored for compute.

Decomposition:
- Package cim_pkg:
  - op encodings OP_WR, OP_WRBUF, OP_COMP, OP_RD
  - state enum
  - default widths ADDR_W / DATA_W
- Sub-module cim_bit_serializer: loads IN_BITS-bit vector, emits one bit/cycle LSB first with a done pulse on the last bit. Instantiated once for the SHIFT phase.

Test Plan:
- Reset then write weight addr=0x1A5 data=0xBEEF -> cim_wrt high exactly at T+1 with cim_a=0x1A5, cim_d=0xBEEF; cmd_ready back at T+2; no rsp_valid.
- Compute addr=0x003 data=0x00B5 model=1, macro model returns q=0x1234 on read -> cim_set at T+1; cim_inbit sequence 1,0,1,0,1,1,0,1 over T+2..T+9; cim_wait T+10..T+11; cim_read T+12; rsp_valid at T+14 with rsp_data=0x1234.
- Read addr=0x0FF with q=0xA5A5, rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable all 5 cycles; cmd_ready=0 and a new cmd_valid is ignored until the handshake.
- WAIT_CYC=0, READ_LAT=3 build, compute data=0x0001 -> cim_read immediately after the last SHIFT cycle; q sampled 3 cycles later; cim_wait never high.
- rst asserted in the 4th SHIFT cycle -> next cycle all strobes 0, busy=0, cmd_ready=1, no rsp_valid; a following write completes normally.
- Random command stream with random rsp_ready, checked against a scoreboard model -> one-hot strobe invariant holds every cycle; responses match model q in order.
